// File: rtl/gpo_pkg.sv
// Shared opcode constants, FSM state encoding and PULSE length width for the
// gpo arbiter slice.
package gpo_pkg;

  localparam int unsigned PULSE_LEN_W = 16;
  localparam int unsigned GPO_W       = 32;

  localparam logic [2:0] OP_WRITE  = 3'd0;
  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_CLR    = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_PULSE  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_PWAIT = 2'd2,
    ST_PCLR  = 2'd3
  } gpo_state_e;

  function automatic logic op_is_reserved(input logic [2:0] op);
    return op > OP_PULSE;
  endfunction

  // PULSE raises the selected bits; the matching clear happens in PCLR.
  function automatic logic [GPO_W-1:0] gpo_next_value(
    input logic [2:0]       op,
    input logic [GPO_W-1:0] cur,
    input logic [GPO_W-1:0] mask,
    input logic [GPO_W-1:0] data
  );
    logic [GPO_W-1:0] nv;
    nv = cur;
    case (op)
      OP_WRITE:  nv = (cur & ~mask) | (data & mask);
      OP_SET:    nv = cur | mask;
      OP_CLR:    nv = cur & ~mask;
      OP_TOGGLE: nv = cur ^ mask;
      OP_PULSE:  nv = cur | mask;
      default:   nv = cur;
    endcase
    return nv;
  endfunction

  function automatic logic [PULSE_LEN_W-1:0] pulse_len(input logic [PULSE_LEN_W-1:0] raw);
    return (raw == '0) ? PULSE_LEN_W'(1) : raw;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; the pointer remembers the last winner and
// moves only when a grant is actually issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    if (grant[0]) begin
      last_d = 1'b0;
    end else if (grant[1]) begin
      last_d = 1'b1;
    end
  end

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/gpo_arbiter.sv
// Arbitrates two command requesters onto the gpo register write port and keeps
// a shadow of the register value, including timed PULSE set/clear sequences.
module gpo_arbiter
  import gpo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_mask,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_mask,
  input  logic [31:0] req1_data,
  output logic        gpo_we,
  output logic [31:0] gpo_wr_data,
  output logic [31:0] gpo_shadow,
  output logic        busy
);

  gpo_state_e             state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [31:0]            mask_q, mask_d;
  logic [PULSE_LEN_W-1:0] cnt_q, cnt_d;
  logic                   gpo_we_q, gpo_we_d;
  logic [31:0]            gpo_wr_data_q, gpo_wr_data_d;
  logic [31:0]            shadow_q, shadow_d;

  logic [1:0]  grant;
  logic        arb_enable;
  logic        accept;
  logic [2:0]  sel_op;
  logic [31:0] sel_mask;
  logic [31:0] sel_data;
  logic [31:0] sel_value;

  assign arb_enable = (state_q == ST_IDLE) && rst_n;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .enable (arb_enable),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  assign sel_op    = grant[1] ? req1_op   : req0_op;
  assign sel_mask  = grant[1] ? req1_mask : req0_mask;
  assign sel_data  = grant[1] ? req1_data : req0_data;
  assign sel_value = gpo_next_value(sel_op, shadow_q, sel_mask, sel_data);

  // The write value is formed at acceptance, so only the mask and the pulse
  // length have to be held for the rest of the command.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    gpo_we_d      = 1'b0;
    gpo_wr_data_d = gpo_wr_data_q;
    shadow_d      = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = sel_op;
          mask_d = sel_mask;
          if (!op_is_reserved(sel_op)) begin
            state_d       = ST_ISSUE;
            gpo_we_d      = 1'b1;
            gpo_wr_data_d = sel_value;
            shadow_d      = sel_value;
            if (sel_op == OP_PULSE) begin
              cnt_d = pulse_len(sel_data[PULSE_LEN_W-1:0]);
            end
          end
        end
      end
      ST_ISSUE: begin
        state_d = (op_q == OP_PULSE) ? ST_PWAIT : ST_IDLE;
      end
      ST_PWAIT: begin
        if (cnt_q <= PULSE_LEN_W'(1)) begin
          state_d       = ST_PCLR;
          cnt_d         = '0;
          gpo_we_d      = 1'b1;
          gpo_wr_data_d = shadow_q & ~mask_q;
          shadow_d      = shadow_q & ~mask_q;
        end else begin
          cnt_d = cnt_q - PULSE_LEN_W'(1);
        end
      end
      ST_PCLR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      mask_q        <= '0;
      cnt_q         <= '0;
      gpo_we_q      <= 1'b0;
      gpo_wr_data_q <= '0;
      shadow_q      <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      gpo_we_q      <= gpo_we_d;
      gpo_wr_data_q <= gpo_wr_data_d;
      shadow_q      <= shadow_d;
    end
  end

  assign gpo_we      = gpo_we_q;
  assign gpo_wr_data = gpo_wr_data_q;
  assign gpo_shadow  = shadow_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpo_arbiter.sv
// Directed and randomized checks of gpo_arbiter against a transaction-level
// model of the arbitration and register-update rules.
module tb_gpo_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_mask, req1_mask;
  logic [31:0] req0_data, req1_data;
  logic        gpo_we;
  logic [31:0] gpo_wr_data;
  logic [31:0] gpo_shadow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_shadow;
  int          model_last;

  gpo_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_mask   (req0_mask),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_mask   (req1_mask),
    .req1_data   (req1_data),
    .gpo_we      (gpo_we),
    .gpo_wr_data (gpo_wr_data),
    .gpo_shadow  (gpo_shadow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Register update rules expressed directly as arithmetic on the tracked value.
  function automatic logic [31:0] model_value(input int op, input logic [31:0] cur,
                                              input logic [31:0] mask, input logic [31:0] data);
    case (op)
      0:       return (cur & ~mask) | (data & mask);
      1, 4:    return cur | mask;
      2:       return cur & ~mask;
      3:       return cur ^ mask;
      default: return cur;
    endcase
  endfunction

  task automatic applyStimulus(input logic v0, input logic [2:0] op0, input logic [31:0] m0,
                               input logic [31:0] d0, input logic v1, input logic [2:0] op1,
                               input logic [31:0] m1, input logic [31:0] d1);
    req0_valid = v0; req0_op = op0; req0_mask = m0; req0_data = d0;
    req1_valid = v1; req1_op = op1; req1_mask = m1; req1_data = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, ":we"}, {31'b0, gpo_we}, 32'd0);
    checkOutput({tag, ":wr_data"}, gpo_wr_data, 32'd0);
    checkOutput({tag, ":shadow"}, gpo_shadow, 32'd0);
    checkOutput({tag, ":busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, ":ready"}, {30'b0, req1_ready, req0_ready}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    tick();
    tick();
    model_shadow = 32'd0;
    model_last   = 1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    #1;
  endtask

  // Called in IDLE with at least one requester valid; follows one command to
  // completion and leaves the bench at the first IDLE cycle afterwards.
  task automatic run_txn(input string tag);
    int          winner;
    int          op;
    int          len;
    logic [31:0] mask, data, nv;
    if (req0_valid && req1_valid) winner = 1 - model_last;
    else winner = req0_valid ? 0 : 1;
    #1;
    checkOutput({tag, ":grant"}, {30'b0, req1_ready, req0_ready}, (winner == 0) ? 32'd1 : 32'd2);
    op   = (winner == 0) ? int'(req0_op)   : int'(req1_op);
    mask = (winner == 0) ? req0_mask : req1_mask;
    data = (winner == 0) ? req0_data : req1_data;
    tick();
    model_last = winner;
    if (winner == 0) begin
      req0_mask = $urandom; req0_data = $urandom;
    end else begin
      req1_mask = $urandom; req1_data = $urandom;
    end
    if (op > 4) begin
      checkOutput({tag, ":rsv_we"}, {31'b0, gpo_we}, 32'd0);
      checkOutput({tag, ":rsv_busy"}, {31'b0, busy}, 32'd0);
      checkOutput({tag, ":rsv_shadow"}, gpo_shadow, model_shadow);
      return;
    end
    nv = model_value(op, model_shadow, mask, data);
    model_shadow = nv;
    checkOutput({tag, ":issue_we"}, {31'b0, gpo_we}, 32'd1);
    checkOutput({tag, ":issue_data"}, gpo_wr_data, nv);
    checkOutput({tag, ":issue_shadow"}, gpo_shadow, nv);
    checkOutput({tag, ":issue_busy"}, {31'b0, busy}, 32'd1);
    checkOutput({tag, ":issue_ready"}, {30'b0, req1_ready, req0_ready}, 32'd0);
    if (op != 4) begin
      tick();
      checkOutput({tag, ":done_we"}, {31'b0, gpo_we}, 32'd0);
      checkOutput({tag, ":done_busy"}, {31'b0, busy}, 32'd0);
    end else begin
      len = (data[15:0] == 16'd0) ? 1 : int'(data[15:0]);
      for (int i = 0; i < len; i++) begin
        tick();
        checkOutput({tag, ":pwait_we"}, {31'b0, gpo_we}, 32'd0);
        checkOutput({tag, ":pwait_busy"}, {31'b0, busy}, 32'd1);
        checkOutput({tag, ":pwait_ready"}, {30'b0, req1_ready, req0_ready}, 32'd0);
      end
      tick();
      model_shadow = model_shadow & ~mask;
      checkOutput({tag, ":pclr_we"}, {31'b0, gpo_we}, 32'd1);
      checkOutput({tag, ":pclr_data"}, gpo_wr_data, model_shadow);
      checkOutput({tag, ":pclr_shadow"}, gpo_shadow, model_shadow);
      tick();
      checkOutput({tag, ":pdone_we"}, {31'b0, gpo_we}, 32'd0);
      checkOutput({tag, ":pdone_busy"}, {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    logic        v0, v1;
    logic [2:0]  op0, op1;
    logic [31:0] m0, m1, d0, d1, r;

    rst_n = 1'b0;
    applyStimulus(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd0);
    #1;
    do_reset("reset_initial");

    // Single WRITE from requester 0.
    applyStimulus(1'b1, 3'd0, 32'h0000_FFFF, 32'h1234_ABCD, 1'b0, 3'd0, 32'd0, 32'd0);
    run_txn("write0");
    checkOutput("write0_value", gpo_shadow, 32'h0000_ABCD);

    applyStimulus(1'b1, 3'd1, 32'hF000_0000, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0);
    run_txn("set");
    checkOutput("set_value", gpo_shadow, 32'hF000_ABCD);
    applyStimulus(1'b1, 3'd2, 32'h0000_000F, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0);
    run_txn("clr");
    checkOutput("clr_value", gpo_shadow, 32'hF000_ABC0);
    applyStimulus(1'b1, 3'd3, 32'h0000_00F0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0);
    run_txn("toggle");
    checkOutput("toggle_value", gpo_shadow, 32'hF000_AB30);

    // Both requesters streaming SET commands after reset.
    do_reset("reset_stream");
    applyStimulus(1'b1, 3'd1, 32'h0000_0001, 32'd0, 1'b1, 3'd1, 32'h0000_0100, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stream_order", (i % 2 == 0) ? {31'b0, req0_valid} : {31'b0, req1_valid}, 32'd1);
      run_txn("stream");
    end

    // PULSE from requester 1 while requester 0 waits.
    do_reset("reset_pulse");
    applyStimulus(1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0);
    run_txn("pulse_prep");
    applyStimulus(1'b1, 3'd1, 32'h0000_0002, 32'd0, 1'b1, 3'd4, 32'h0000_0001, 32'd3);
    run_txn("pulse3");
    checkOutput("pulse3_cleared", gpo_shadow, 32'd0);
    req1_valid = 1'b0;
    run_txn("pulse_waiter");
    checkOutput("pulse_waiter_value", gpo_shadow, 32'h0000_0002);

    applyStimulus(1'b1, 3'd4, 32'h0000_0080, 32'h0001_0000, 1'b0, 3'd0, 32'd0, 32'd0);
    run_txn("pulse_len0");

    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_txn("reserved6");
    checkOutput("reserved6_value", gpo_shadow, 32'h0000_0002);

    // Reset in the middle of a long pulse must cancel the pending clear.
    applyStimulus(1'b1, 3'd4, 32'h0000_0F00, 32'd20, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    checkOutput("midrst_grant", {30'b0, req1_ready, req0_ready}, 32'd1);
    tick();
    tick();
    tick();
    checkOutput("midrst_busy_before", {31'b0, busy}, 32'd1);
    applyStimulus(1'b1, 3'd1, 32'd1, 32'd0, 1'b1, 3'd1, 32'd1, 32'd0);
    do_reset("midrst");
    for (int i = 0; i < 30; i++) begin
      tick();
      checkOutput("midrst_no_clear_we", {31'b0, gpo_we}, 32'd0);
    end
    checkOutput("midrst_shadow_after", gpo_shadow, 32'd0);

    // Randomized mix of commands, ties and idle cycles.
    for (int n = 0; n < 60; n++) begin
      r   = $urandom;
      v0  = r[0];
      v1  = r[1];
      op0 = 3'($urandom_range(0, 7));
      op1 = 3'($urandom_range(0, 7));
      m0  = $urandom;
      m1  = $urandom;
      d0  = (op0 == 3'd4) ? 32'($urandom_range(0, 4)) : $urandom;
      d1  = (op1 == 3'd4) ? 32'($urandom_range(0, 4)) : $urandom;
      applyStimulus(v0, op0, m0, d0, v1, op1, m1, d1);
      if (!v0 && !v1) begin
        #1;
        checkOutput("rand_idle_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        checkOutput("rand_idle_busy", {31'b0, busy}, 32'd0);
        tick();
        checkOutput("rand_idle_we", {31'b0, gpo_we}, 32'd0);
      end else begin
        run_txn("rand");
      end
    end
    checkOutput("rand_final_shadow", gpo_shadow, model_shadow);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
